// File: rtl/ble_cmd_rx_if.sv
// Signal bundle between the BLE UART receiver and its surroundings.
// The slave modport is the receiver's view. The master modport is the view of whoever drives RX and rider_off.
interface ble_cmd_rx_if;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       pwr_up;

  modport slave (
    input  RX,
    input  rider_off,
    output rx_data,
    output rx_rdy,
    output frame_err,
    output pwr_up
  );

  modport master (
    output RX,
    output rider_off,
    input  rx_data,
    input  rx_rdy,
    input  frame_err,
    input  pwr_up
  );
endinterface

// File: rtl/ble_cmd_rx.sv
// 8N1 UART receiver for the Segway BLE link, followed by the go/stop authorisation FSM.
// The authorisation FSM produces pwr_up from the received commands and the rider_off status.
module ble_cmd_rx #(
  parameter int         BAUD_DIV = 5208,
  parameter logic [7:0] GO_CMD   = 8'h67,
  parameter logic [7:0] STOP_CMD = 8'h73
) (
  input logic      clk,
  input logic      rst,
  ble_cmd_rx_if.slave bus
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
  // Reloading with BAUD_DIV-1 and expiring at 0 gives exactly BAUD_DIV cycles between samples.
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} authState_t;

  rxState_t   r_rxState;
  authState_t r_authState;

  logic          r_rx1, r_rx2, r_rx3;
  logic [CW-1:0] r_baudCnt;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_rxData;
  logic          r_rxRdy;
  logic          r_frameErr;
  logic          r_pwrUp;

  logic w_fall;
  logic w_expired;

  assign w_fall    = r_rx3 & ~r_rx2;
  assign w_expired = (r_baudCnt == '0);

  assign bus.rx_data   = r_rxData;
  assign bus.rx_rdy    = r_rxRdy;
  assign bus.frame_err = r_frameErr;
  assign bus.pwr_up    = r_pwrUp;

  // The synchroniser is preset to the idle line level, so reset cannot create a false start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx1 <= 1'b1;
      r_rx2 <= 1'b1;
      r_rx3 <= 1'b1;
    end else begin
      r_rx1 <= bus.RX;
      r_rx2 <= r_rx1;
      r_rx3 <= r_rx2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxState  <= IDLE;
      r_baudCnt  <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_rxData   <= '0;
      r_rxRdy    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_rxRdy    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_rxState)
        IDLE: begin
          if (w_fall) begin
            r_baudCnt <= HALF_LOAD;
            r_rxState <= START;
          end
        end
        START: begin
          if (w_expired) begin
            if (r_rx2) begin
              r_rxState <= IDLE;
            end else begin
              r_baudCnt <= FULL_LOAD;
              r_bitCnt  <= 3'd7;
              r_rxState <= DATA;
            end
          end else begin
            r_baudCnt <= r_baudCnt - CW'(1);
          end
        end
        DATA: begin
          if (w_expired) begin
            r_shift   <= {r_rx2, r_shift[7:1]};
            r_baudCnt <= FULL_LOAD;
            if (r_bitCnt == 3'd0) begin
              r_rxState <= STOP;
            end else begin
              r_bitCnt <= r_bitCnt - 3'd1;
            end
          end else begin
            r_baudCnt <= r_baudCnt - CW'(1);
          end
        end
        STOP: begin
          if (w_expired) begin
            if (r_rx2) begin
              r_rxData <= r_shift;
              r_rxRdy  <= 1'b1;
            end else begin
              r_frameErr <= 1'b1;
            end
            r_rxState <= IDLE;
          end else begin
            r_baudCnt <= r_baudCnt - CW'(1);
          end
        end
        default: r_rxState <= IDLE;
      endcase
    end
  end

  // PWR1 ignores rider_off except on a STOP byte. PWR2 drops out on rider_off alone, and rider_off beats GO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_authState <= OFF;
      r_pwrUp     <= 1'b0;
    end else begin
      case (r_authState)
        OFF: begin
          if (r_rxRdy && (r_rxData == GO_CMD)) begin
            r_authState <= PWR1;
            r_pwrUp     <= 1'b1;
          end
        end
        PWR1: begin
          if (r_rxRdy && (r_rxData == STOP_CMD)) begin
            if (bus.rider_off) begin
              r_authState <= OFF;
              r_pwrUp     <= 1'b0;
            end else begin
              r_authState <= PWR2;
            end
          end
        end
        PWR2: begin
          if (bus.rider_off) begin
            r_authState <= OFF;
            r_pwrUp     <= 1'b0;
          end else if (r_rxRdy && (r_rxData == GO_CMD)) begin
            r_authState <= PWR1;
          end
        end
        default: begin
          r_authState <= OFF;
          r_pwrUp     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_cmd_rx.sv
// Directed bench for ble_cmd_rx, run with a short baud divisor.
// Each scenario task drives whole UART frames and checks the resulting outputs and pwr_up sequencing.
module tb_ble_cmd_rx;

  localparam int BAUD = 16;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  int   rdyHigh;
  int   errHigh;
  logic prevRdy;
  logic pwrAtRdy;
  logic pwrAfterRdy;

  ble_cmd_rx_if bus ();

  ble_cmd_rx #(.BAUD_DIV(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count every cycle rx_rdy and frame_err are high, and capture pwr_up on the rdy cycle and on the cycle after it.
  always @(negedge clk) begin
    if (prevRdy) pwrAfterRdy = bus.pwr_up;
    if (bus.rx_rdy === 1'b1) begin
      rdyHigh++;
      pwrAtRdy = bus.pwr_up;
    end
    if (bus.frame_err === 1'b1) errHigh++;
    prevRdy = bus.rx_rdy;
  end

  // Drive one 8N1 frame LSB first. The line is left idle high afterwards.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    bus.RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    bus.RX = stopBit;
    repeat (BAUD) @(negedge clk);
    bus.RX = 1'b1;
  endtask

  task automatic test_reset;
    assertCount++;
    if (bus.rx_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
    assertCount++;
    if (bus.rx_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rx_rdy: got %b expected 0", bus.rx_rdy); end
    assertCount++;
    if (bus.frame_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    assertCount++;
    if (bus.pwr_up !== 1'b0) begin failCount++; $display("[TB] FAIL reset_pwr_up: got %b expected 0", bus.pwr_up); end
  endtask

  task automatic test_go;
    int r0, e0;
    r0 = rdyHigh; e0 = errHigh;
    applyStimulus(8'h67, 1'b1);
    repeat (2) @(negedge clk);
    assertCount++;
    if (rdyHigh - r0 !== 1) begin failCount++; $display("[TB] FAIL go_rdy_cycles: got %0d expected 1", rdyHigh - r0); end
    assertCount++;
    if (bus.rx_data !== 8'h67) begin failCount++; $display("[TB] FAIL go_rx_data: got %h expected 67", bus.rx_data); end
    assertCount++;
    if (pwrAtRdy !== 1'b0) begin failCount++; $display("[TB] FAIL go_pwr_during_rdy: got %b expected 0", pwrAtRdy); end
    assertCount++;
    if (pwrAfterRdy !== 1'b1) begin failCount++; $display("[TB] FAIL go_pwr_after_rdy: got %b expected 1", pwrAfterRdy); end
    assertCount++;
    if (errHigh - e0 !== 0) begin failCount++; $display("[TB] FAIL go_frame_err: got %0d expected 0", errHigh - e0); end
  endtask

  task automatic test_stop_keep;
    bus.rider_off = 1'b0;
    applyStimulus(8'h73, 1'b1);
    repeat (2) @(negedge clk);
    assertCount++;
    if (bus.rx_data !== 8'h73) begin failCount++; $display("[TB] FAIL stop_keep_rx_data: got %h expected 73", bus.rx_data); end
    assertCount++;
    if (bus.pwr_up !== 1'b1) begin failCount++; $display("[TB] FAIL stop_keep_pwr: got %b expected 1", bus.pwr_up); end
  endtask

  // From PWR2, a GO returns to PWR1, where rider_off alone must not drop power.
  task automatic test_rego;
    applyStimulus(8'h67, 1'b1);
    repeat (2) @(negedge clk);
    bus.rider_off = 1'b1;
    repeat (4) @(negedge clk);
    assertCount++;
    if (bus.pwr_up !== 1'b1) begin failCount++; $display("[TB] FAIL rego_pwr1_rider_off: got %b expected 1", bus.pwr_up); end
  endtask

  task automatic test_stop_rider;
    bus.rider_off = 1'b1;
    applyStimulus(8'h73, 1'b1);
    repeat (2) @(negedge clk);
    assertCount++;
    if (pwrAtRdy !== 1'b1) begin failCount++; $display("[TB] FAIL stop_rider_pwr_during_rdy: got %b expected 1", pwrAtRdy); end
    assertCount++;
    if (pwrAfterRdy !== 1'b0) begin failCount++; $display("[TB] FAIL stop_rider_pwr_after_rdy: got %b expected 0", pwrAfterRdy); end
    bus.rider_off = 1'b0;
  endtask

  task automatic test_rider_drop;
    applyStimulus(8'h67, 1'b1);
    applyStimulus(8'h73, 1'b1);
    repeat (3) @(negedge clk);
    bus.rider_off = 1'b1;
    assertCount++;
    if (bus.pwr_up !== 1'b1) begin failCount++; $display("[TB] FAIL rider_drop_before_edge: got %b expected 1", bus.pwr_up); end
    @(negedge clk);
    assertCount++;
    if (bus.pwr_up !== 1'b0) begin failCount++; $display("[TB] FAIL rider_drop_after_edge: got %b expected 0", bus.pwr_up); end
    bus.rider_off = 1'b0;
  endtask

  task automatic test_other_bytes;
    int r0;
    r0 = rdyHigh;
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h73, 1'b1);
    repeat (3) @(negedge clk);
    assertCount++;
    if (rdyHigh - r0 !== 2) begin failCount++; $display("[TB] FAIL other_rdy_cycles: got %0d expected 2", rdyHigh - r0); end
    assertCount++;
    if (bus.rx_data !== 8'h73) begin failCount++; $display("[TB] FAIL other_rx_data: got %h expected 73", bus.rx_data); end
    assertCount++;
    if (bus.pwr_up !== 1'b0) begin failCount++; $display("[TB] FAIL other_pwr: got %b expected 0", bus.pwr_up); end
  endtask

  // The STOP byte with a bad stop bit is sent with rider_off high in PWR1; if it reached the auth FSM, power would drop.
  task automatic test_glitch_frame_err;
    int r0, e0;
    applyStimulus(8'h67, 1'b1);
    repeat (3) @(negedge clk);
    r0 = rdyHigh; e0 = errHigh;
    bus.RX = 1'b0;
    repeat (BAUD / 2 - 3) @(negedge clk);
    bus.RX = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    assertCount++;
    if (rdyHigh - r0 !== 0 || errHigh - e0 !== 0) begin
      failCount++; $display("[TB] FAIL glitch_no_output: rdy %0d err %0d expected 0 0", rdyHigh - r0, errHigh - e0);
    end
    bus.rider_off = 1'b1;
    applyStimulus(8'h73, 1'b0);
    repeat (3) @(negedge clk);
    assertCount++;
    if (errHigh - e0 !== 1) begin failCount++; $display("[TB] FAIL ferr_pulse_cycles: got %0d expected 1", errHigh - e0); end
    assertCount++;
    if (rdyHigh - r0 !== 0) begin failCount++; $display("[TB] FAIL ferr_no_rdy: got %0d expected 0", rdyHigh - r0); end
    assertCount++;
    if (bus.rx_data !== 8'h67) begin failCount++; $display("[TB] FAIL ferr_rx_data: got %h expected 67", bus.rx_data); end
    assertCount++;
    if (bus.pwr_up !== 1'b1) begin failCount++; $display("[TB] FAIL ferr_pwr: got %b expected 1", bus.pwr_up); end
    bus.rider_off = 1'b0;
    repeat (BAUD) @(negedge clk);
  endtask

  // 0x67 LSB first is 1,1,1,0,0,1,1,0. Reset lands in bit 5, and the line then stays idle.
  task automatic test_reset_midframe;
    int r0, e0;
    logic [7:0] b;
    b = 8'h67;
    r0 = rdyHigh; e0 = errHigh;
    bus.RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    bus.RX = 1'b1;
    #2 rst = 1'b1;
    #1;
    assertCount++;
    if (bus.pwr_up !== 1'b0) begin failCount++; $display("[TB] FAIL rst_async_pwr: got %b expected 0", bus.pwr_up); end
    assertCount++;
    if (bus.rx_data !== 8'h00) begin failCount++; $display("[TB] FAIL rst_async_rx_data: got %h expected 00", bus.rx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BAUD) @(negedge clk);
    assertCount++;
    if (rdyHigh - r0 !== 0 || errHigh - e0 !== 0) begin
      failCount++; $display("[TB] FAIL rst_partial_frame: rdy %0d err %0d expected 0 0", rdyHigh - r0, errHigh - e0);
    end
    applyStimulus(8'h67, 1'b1);
    repeat (2) @(negedge clk);
    assertCount++;
    if (bus.pwr_up !== 1'b1) begin failCount++; $display("[TB] FAIL rst_recover_pwr: got %b expected 1", bus.pwr_up); end
  endtask

  // Second start edge follows the first stop bit with no idle gap; this leaves the auth FSM in PWR2.
  task automatic test_back_to_back;
    int r0;
    r0 = rdyHigh;
    applyStimulus(8'h67, 1'b1);
    applyStimulus(8'h73, 1'b1);
    repeat (3) @(negedge clk);
    assertCount++;
    if (rdyHigh - r0 !== 2) begin failCount++; $display("[TB] FAIL b2b_rdy_cycles: got %0d expected 2", rdyHigh - r0); end
    assertCount++;
    if (bus.rx_data !== 8'h73) begin failCount++; $display("[TB] FAIL b2b_rx_data: got %h expected 73", bus.rx_data); end
    assertCount++;
    if (bus.pwr_up !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_pwr: got %b expected 1", bus.pwr_up); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.RX = 1'b1;
    bus.rider_off = 1'b0;
    assertCount = 0;
    failCount = 0;
    rdyHigh = 0;
    errHigh = 0;
    prevRdy = 1'b0;
    pwrAtRdy = 1'b0;
    pwrAfterRdy = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_go;
    test_stop_keep;
    test_rego;
    test_stop_rider;
    test_rider_drop;
    test_other_bytes;
    test_glitch_frame_err;
    test_reset_midframe;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ble_cmd_rx.md
Name: ble_cmd_rx

Overview:
UART receive front end plus command authorisation for the Segway BLE link. It sits between the RX pin (driven by the BLE module, or by UART_tx in the bench) and the balance/steering core. It deserialises 8N1 frames and decodes the 'g' (go) and 's' (stop) commands. Together with the rider_off status from the load-cell logic, it produces the pwr_up enable that gates motor drive.

Parameters:
BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
GO_CMD, 8'h67, byte that requests power-up.
STOP_CMD, 8'h73, byte that requests power-down.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
RX  in  1  serial input from the BLE module; idles high; asynchronous to clk
rider_off  in  1  high when combined load-cell weight is below the rider threshold
rx_data  out  8  last good received byte
rx_rdy  out  1  one-cycle pulse when rx_data updates
frame_err  out  1  one-cycle pulse when a stop bit is sampled low
pwr_up  out  1  motor/balance enable

Behaviour:
- Reset values: all outputs 0. Synchroniser flops preset to 1. Receive FSM in IDLE. Auth FSM in OFF. Baud and bit counters cleared.
- RX synchronisation: 2 flops, then a third flop for edge detect. A start is a falling edge on the synchronised RX.
- Receive FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a falling edge; load the baud counter with BAUD_DIV/2 (integer divide).
  - START: when the counter expires, sample RX.
    - RX = 1 is a false start: go back to IDLE with no outputs.
    - RX = 0: reload BAUD_DIV and go to DATA.
  - DATA: sample every BAUD_DIV cycles and shift in LSB first. After 8 samples, reload BAUD_DIV and go to STOP.
  - STOP: sample RX.
    - RX = 1: rx_data ← shift register; rx_rdy = 1 for exactly one cycle; go to IDLE.
    - RX = 0: frame_err = 1 for one cycle; rx_data unchanged; go to IDLE.
- rx_data holds its value until the next good frame.
- Falling edges on RX are ignored outside IDLE.
- Back-to-back frames are supported: a start edge in the first IDLE cycle after STOP is accepted.
- Auth FSM states: OFF, PWR1, PWR2. It acts only on cycles where rx_rdy = 1, except where a rider_off condition is noted.
  - OFF: rx_data == GO_CMD → PWR1.
  - PWR1: rx_data == STOP_CMD → OFF if rider_off = 1 in that cycle, else PWR2. Any other byte: stay.
  - PWR2: rider_off = 1 in any cycle → OFF. rx_data == GO_CMD → PWR1.
  - If rider_off = 1 and GO_CMD arrive in the same cycle in PWR2, rider_off wins: go to OFF.
- pwr_up is registered: it is 1 in PWR1 and PWR2. It changes on the clock edge after the qualifying rx_rdy or rider_off cycle (1-cycle latency).
- Bytes other than GO_CMD/STOP_CMD are never acted on. A frame_err frame never reaches the auth FSM.
- rst asserted mid-frame or mid-state: both FSMs go to IDLE/OFF immediately and asynchronously, and pwr_up drops at once. After rst is released, a frame already in progress is not recovered; the next falling edge starts a fresh receive.
- Counters are sized as ceil(log2(BAUD_DIV+1)) bits. They count down to 0, and expiry is the cycle the count equals 0; there is no wrap-around.

Test Plan:
- Reset, then UART_tx sends 8'h67 → rx_rdy pulses once ~10×5208 cycles after the start edge; rx_data = 8'h67; pwr_up = 1 on the next clk.
- pwr_up = 1, rider_off = 0, send 8'h73 → pwr_up stays 1 (PWR2). Then raise rider_off → pwr_up = 0 one cycle later.
- pwr_up = 1, rider_off = 1, send 8'h73 → pwr_up = 0 one cycle after rx_rdy.
- From OFF, send 8'h41, then 8'h73 → two rx_rdy pulses, rx_data = 8'h73, pwr_up stays 0.
- Drive RX low for 1000 cycles (glitch shorter than BAUD_DIV/2 = 2604), then high → no rx_rdy, no frame_err, FSM in IDLE. Then send a frame with the stop bit forced low → frame_err pulses once, rx_data unchanged, pwr_up unchanged.
- Assert rst halfway through a 8'h67 frame while pwr_up = 1 → pwr_up = 0 immediately. The partial frame yields no rx_rdy. A following clean 8'h67 sets pwr_up = 1.
